// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, LSB first, one stop bit, two-flop rx synchronizer.
// Define UART_RX_FRAME_ERR_EN to check the stop bit and pulse frame_err on a low stop bit.
module uart_rx #(
   parameter int CLOCKS_PER_BIT = 4,
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 busy
);
   localparam int CW = $clog2(CLOCKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] MID = CW'(CLOCKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
   state_t state;
   logic rx_m;
   logic rx_s;
   logic [CW-1:0] baud;
   logic [BW-1:0] bit_cnt;
   logic [DATA_BITS-1:0] shift;
   assign busy = state != IDLE;
`ifndef UART_RX_FRAME_ERR_EN
   assign frame_err = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         state <= IDLE;
         baud <= '0;
         bit_cnt <= '0;
         shift <= '0;
         data <= '0;
         valid <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
         frame_err <= 1'b0;
`endif
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         valid <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
         frame_err <= 1'b0;
`endif
         baud <= baud + 1'b1;
         case (state)
            IDLE: begin
               baud <= '0;
               if (!rx_s) state <= START;
            end
            START: if (baud == MID) begin
               baud <= '0;
               bit_cnt <= '0;
               state <= rx_s ? IDLE : DATA;
            end
            DATA: if (baud == LAST) begin
               baud <= '0;
               shift <= {rx_s, shift[DATA_BITS-1:1]};
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == LAST_BIT) state <= STOP;
            end
            STOP: if (baud == LAST) begin
               baud <= '0;
`ifdef UART_RX_FRAME_ERR_EN
               if (rx_s) begin
                  data <= shift;
                  valid <= 1'b1;
                  state <= IDLE;
               end else begin
                  frame_err <= 1'b1;
                  state <= WAIT_HIGH;
               end
`else
               data <= shift;
               valid <= 1'b1;
               state <= rx_s ? IDLE : WAIT_HIGH;
`endif
            end
            WAIT_HIGH: begin
               baud <= '0;
               if (rx_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frames with a scoreboard of expected valid/frame_err pulses.
module tb_uart_rx;
`ifdef UART_RX_FRAME_ERR_EN
   localparam bit FE_EN = 1'b1;
`else
   localparam bit FE_EN = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx = 1'b1;
   logic [7:0] data;
   logic valid;
   logic frame_err;
   logic busy;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   typedef struct {logic err; logic [7:0] d;} exp_t;
   typedef struct {logic [7:0] d; logic stop; int hold; logic exp_valid; logic exp_err;} vec_t;
   exp_t sb[$];
   int vt[$];
   logic [7:0] model_data = 8'h00;
   vec_t vecs[6];

   uart_rx #(.CLOCKS_PER_BIT(4), .DATA_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx), .data(data),
      .valid(valid), .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input int a, input int e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (valid || frame_err)) begin
         chk("valid_ferr_exclusive", int'(valid & frame_err), 0);
         if (valid) vt.push_back(cyc);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got valid=%0b frame_err=%0b data=%0h expected no pulse", valid, frame_err, data);
         end else begin
            e = sb.pop_front();
            chk("pulse_kind_ferr", int'(frame_err), int'(e.err));
            chk("pulse_data", int'(data), int'(e.d));
         end
      end
   end

   function automatic vec_t mk(input logic [7:0] d, input logic stop, input int hold);
      vec_t v;
      v.d = d;
      v.stop = stop;
      v.hold = hold;
      v.exp_err = FE_EN && !stop;
      v.exp_valid = !v.exp_err;
      return v;
   endfunction

   task automatic send_bit(input logic b);
      rx = b;
      repeat (4) @(negedge clk);
   endtask

   task automatic push_frame(input vec_t v);
      exp_t e;
      e.err = v.exp_err;
      e.d = v.exp_valid ? v.d : model_data;
      if (v.exp_valid) model_data = v.d;
      sb.push_back(e);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(v.d[i]);
      send_bit(v.stop);
   endtask

   task automatic after_frame(input vec_t v);
      if (!v.stop) begin
         rx = 1'b0;
         repeat (v.hold) @(negedge clk);
         if (v.hold > 0) chk("break_busy", int'(busy), 1);
      end
      rx = 1'b1;
      repeat (12) @(negedge clk);
      chk("idle_busy", int'(busy), 0);
      chk("sb_drained", sb.size(), 0);
      chk("data_hold", int'(data), int'(model_data));
   endtask

   initial begin
      vecs[0] = mk(8'hA5, 1'b1, 0);
      vecs[1] = mk(8'h5A, 1'b0, 40);
      vecs[2] = mk(8'h01, 1'b1, 0);
      vecs[3] = mk(8'h80, 1'b1, 0);
      vecs[4] = mk(8'hC3, 1'b0, 0);
      vecs[5] = mk(8'h7E, 1'b1, 0);
      repeat (2) @(negedge clk);
      chk("rst_data", int'(data), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_ferr", int'(frame_err), 0);
      chk("rst_busy", int'(busy), 0);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         push_frame(vecs[i]);
         after_frame(vecs[i]);
      end
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      chk("glitch_busy_hi", int'(busy), 1);
      repeat (4) @(negedge clk);
      chk("glitch_busy_lo", int'(busy), 0);
      chk("glitch_sb", sb.size(), 0);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      chk("mid_busy", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_data", int'(data), 0);
      chk("midrst_valid", int'(valid), 0);
      chk("midrst_ferr", int'(frame_err), 0);
      chk("midrst_busy", int'(busy), 0);
      model_data = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      push_frame(mk(8'h3C, 1'b1, 0));
      after_frame(mk(8'h3C, 1'b1, 0));
      vt.delete();
      push_frame(mk(8'h00, 1'b1, 0));
      push_frame(mk(8'hFF, 1'b1, 0));
      after_frame(mk(8'hFF, 1'b1, 0));
      chk("b2b_count", vt.size(), 2);
      if (vt.size() == 2) chk("b2b_gap", vt[1] - vt[0], 40);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
